// File: rtl/can_pkg.sv
// Shared constants and types for the CAN receive framer: defaults, field widths
// and the read-side FSM state encoding.
package can_pkg;

    localparam logic [7:0] SOF_BYTE_DEF  = 8'hA5;
    localparam int         MAX_BYTES_DEF = 8;
    localparam int         CSUM_W        = 8;
    localparam int         LEN_W         = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SOF,
        ST_LEN,
        ST_DATA,
        ST_CSUM
    } rd_state_t;

endpackage

// File: rtl/can_rx_bank.sv
// One ping-pong payload bank: byte storage plus the length, checksum and full
// flag captured when a packet commits; full clears when the reader releases it.
module can_rx_bank
    import can_pkg::*;
#(
    parameter int MAX_BYTES = MAX_BYTES_DEF,
    parameter int AW        = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [7:0]        i_wr_data,
    input  logic              i_commit,
    input  logic [LEN_W-1:0]  i_commit_len,
    input  logic [CSUM_W-1:0] i_commit_csum,
    input  logic              i_release,
    input  logic [AW-1:0]     i_rd_addr,
    output logic [7:0]        o_rd_data,
    output logic [LEN_W-1:0]  o_len,
    output logic [CSUM_W-1:0] o_csum,
    output logic              o_full
);

    logic [7:0]        r_mem [MAX_BYTES];
    logic [LEN_W-1:0]  r_len;
    logic [CSUM_W-1:0] r_csum;
    logic              r_full;

    // Payload storage needs no reset: it is only read behind a set full flag.
    always_ff @(posedge clk) begin
        if (i_wr_en)
            r_mem[i_wr_addr] <= i_wr_data;
    end

    // Commit and release never target the same bank in one cycle: commit
    // requires the bank empty, release requires it full.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_full <= 1'b0;
            r_len  <= '0;
            r_csum <= '0;
        end else if (i_commit) begin
            r_full <= 1'b1;
            r_len  <= i_commit_len;
            r_csum <= i_commit_csum;
        end else if (i_release) begin
            r_full <= 1'b0;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];
    assign o_len     = r_len;
    assign o_csum    = r_csum;
    assign o_full    = r_full;

endmodule

// File: rtl/can_rx_framer.sv
// Buffers received CAN payloads in two ping-pong banks and re-emits each one as
// an SOF / length / payload / checksum frame on a valid/ready byte stream.
module can_rx_framer
    import can_pkg::*;
#(
    parameter logic [7:0] SOF_BYTE  = SOF_BYTE_DEF,
    parameter int         MAX_BYTES = MAX_BYTES_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_rx_valid,
    input  logic       i_rx_last,
    input  logic [7:0] i_rx_data,
    output logic       o_out_valid,
    input  logic       i_out_ready,
    output logic [7:0] o_out_data,
    output logic       o_out_last,
    output logic       o_overflow,
    output logic [7:0] o_drop_cnt
);

    localparam int IW = $clog2(MAX_BYTES + 1);
    localparam int AW = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;

    logic              r_wr_bank;
    logic              r_rd_bank;
    logic [IW-1:0]     r_wr_idx;
    logic [IW-1:0]     r_rd_idx;
    logic [CSUM_W-1:0] r_wr_sum;
    logic              r_bad;
    logic              r_overflow;
    logic [7:0]        r_drop_cnt;
    rd_state_t         r_state;
    rd_state_t         w_state_nxt;

    logic [1:0]             w_full;
    logic [1:0]             w_wr_en;
    logic [1:0]             w_commit;
    logic [1:0]             w_release;
    logic [1:0][7:0]        w_rd_data;
    logic [1:0][LEN_W-1:0]  w_len;
    logic [1:0][CSUM_W-1:0] w_csum;

    logic              w_byte_ok;
    logic              w_store;
    logic              w_end;
    logic              w_commit_ok;
    logic              w_drop;
    logic              w_rel;
    logic [LEN_W-1:0]  w_pkt_len;
    logic [CSUM_W-1:0] w_pkt_sum;
    logic [LEN_W-1:0]  w_cur_len;

    for (genvar g = 0; g < 2; g++) begin : g_bank
        assign w_wr_en[g]   = w_store     && (r_wr_bank == 1'(g));
        assign w_commit[g]  = w_commit_ok && (r_wr_bank == 1'(g));
        assign w_release[g] = w_rel       && (r_rd_bank == 1'(g));

        can_rx_bank #(
            .MAX_BYTES (MAX_BYTES),
            .AW        (AW)
        ) u_bank (
            .clk           (clk),
            .reset_n       (reset_n),
            .i_wr_en       (w_wr_en[g]),
            .i_wr_addr     (r_wr_idx[AW-1:0]),
            .i_wr_data     (i_rx_data),
            .i_commit      (w_commit[g]),
            .i_commit_len  (w_pkt_len),
            .i_commit_csum (w_pkt_sum),
            .i_release     (w_release[g]),
            .i_rd_addr     (r_rd_idx[AW-1:0]),
            .o_rd_data     (w_rd_data[g]),
            .o_len         (w_len[g]),
            .o_csum        (w_csum[g]),
            .o_full        (w_full[g])
        );
    end

    // A byte that cannot be stored poisons the whole packet, including the
    // last byte itself, so a drop never leaves a partial frame behind.
    assign w_byte_ok   = !w_full[r_wr_bank] && (r_wr_idx < IW'(MAX_BYTES));
    assign w_store     = i_rx_valid && w_byte_ok;
    assign w_end       = i_rx_valid && i_rx_last;
    assign w_commit_ok = w_end && !r_bad && w_byte_ok;
    assign w_drop      = w_end && !w_commit_ok;
    assign w_pkt_len   = LEN_W'(r_wr_idx) + LEN_W'(1);
    assign w_pkt_sum   = r_wr_sum + i_rx_data + CSUM_W'(w_pkt_len);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_bank  <= 1'b0;
            r_wr_idx   <= '0;
            r_wr_sum   <= '0;
            r_bad      <= 1'b0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_end) begin
                r_wr_idx <= '0;
                r_wr_sum <= '0;
                r_bad    <= 1'b0;
                if (w_commit_ok)
                    r_wr_bank <= ~r_wr_bank;
            end else if (i_rx_valid) begin
                if (w_byte_ok) begin
                    r_wr_idx <= r_wr_idx + IW'(1);
                    r_wr_sum <= r_wr_sum + i_rx_data;
                end else begin
                    r_bad <= 1'b1;
                end
            end
            r_overflow <= w_drop;
            if (w_drop && (r_drop_cnt != 8'hFF))
                r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign o_overflow = r_overflow;
    assign o_drop_cnt = r_drop_cnt;

    assign w_rel     = (r_state == ST_CSUM) && i_out_ready;
    assign w_cur_len = w_len[r_rd_bank];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_rd_bank <= 1'b0;
            r_rd_idx  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_rel)
                r_rd_bank <= ~r_rd_bank;
            if ((r_state == ST_LEN) && i_out_ready)
                r_rd_idx <= '0;
            else if ((r_state == ST_DATA) && i_out_ready)
                r_rd_idx <= r_rd_idx + IW'(1);
        end
    end

    // Outputs decode straight from registered state, so they hold steady
    // through any stall and drop to zero the instant reset asserts.
    always_comb begin
        w_state_nxt = r_state;
        o_out_valid = 1'b0;
        o_out_data  = '0;
        o_out_last  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_full[r_rd_bank])
                    w_state_nxt = ST_SOF;
            end
            ST_SOF: begin
                o_out_valid = 1'b1;
                o_out_data  = SOF_BYTE;
                if (i_out_ready)
                    w_state_nxt = ST_LEN;
            end
            ST_LEN: begin
                o_out_valid = 1'b1;
                o_out_data  = {{(8 - LEN_W){1'b0}}, w_cur_len};
                if (i_out_ready)
                    w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                o_out_valid = 1'b1;
                o_out_data  = w_rd_data[r_rd_bank];
                if (i_out_ready && (r_rd_idx == IW'(w_cur_len) - IW'(1)))
                    w_state_nxt = ST_CSUM;
            end
            ST_CSUM: begin
                o_out_valid = 1'b1;
                o_out_data  = w_csum[r_rd_bank];
                o_out_last  = 1'b1;
                if (i_out_ready)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_can_rx_framer.sv
// Bench for can_rx_framer: directed scenarios plus random traffic, scored
// against a depth-2 packet FIFO model of the ping-pong store.
module tb_can_rx_framer;

    localparam int MAXB = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx_valid = 1'b0;
    logic       rx_last = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       overflow;
    logic [7:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    // Model state: packets held = committed minus released (0..2).
    int         m_occ = 0;
    logic [7:0] m_pkt[$];
    bit         m_bad = 0;
    int         m_drop = 0;
    bit         m_ovf_pend = 0;
    logic [7:0] exp_b[$];
    bit         exp_l[$];
    logic [7:0] obs_q[$];
    bit         obs_l[$];
    bit         p_stall = 0;
    logic [7:0] p_data = 8'h00;
    bit         p_last = 0;

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    can_rx_framer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_rx_valid  (rx_valid),
        .i_rx_last   (rx_last),
        .i_rx_data   (rx_data),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_data  (out_data),
        .o_out_last  (out_last),
        .o_overflow  (overflow),
        .o_drop_cnt  (drop_cnt)
    );

    // Negedge monitor: judges the transfer about to happen at the next posedge.
    always @(negedge clk) begin
        int  sum;
        int  len;
        bit  rel;
        bit  ok;
        logic [7:0] eb;
        bit  el;
        rel = 0;
        if (!reset_n) begin
            m_occ = 0; m_pkt.delete(); m_bad = 0; m_drop = 0; m_ovf_pend = 0;
            exp_b.delete(); exp_l.delete(); p_stall = 0;
            checks++;
            if (out_valid !== 1'b0 || drop_cnt !== 8'h00 || overflow !== 1'b0) begin
                errors++;
                $display("FAIL in_reset valid=%b drop=%0d ovf=%b want 0 0 0", out_valid, drop_cnt, overflow);
            end
        end else begin
            checks++;
            if (overflow !== m_ovf_pend) begin
                errors++;
                $display("FAIL overflow_pulse got %b want %b", overflow, m_ovf_pend);
            end
            checks++;
            if (drop_cnt !== m_drop[7:0]) begin
                errors++;
                $display("FAIL drop_cnt got %0d want %0d", drop_cnt, m_drop);
            end
            if (p_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== p_data || out_last !== p_last) begin
                    errors++;
                    $display("FAIL stall_hold got v=%b d=%h l=%b want v=1 d=%h l=%b",
                             out_valid, out_data, out_last, p_data, p_last);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                obs_q.push_back(out_data);
                obs_l.push_back(out_last);
                checks++;
                if (exp_b.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_byte got %h want none", out_data);
                end else begin
                    eb = exp_b.pop_front();
                    el = exp_l.pop_front();
                    if (out_data !== eb || out_last !== el) begin
                        errors++;
                        $display("FAIL stream_byte got %h/%b want %h/%b", out_data, out_last, eb, el);
                    end
                end
                rel = (out_last === 1'b1);
            end
            p_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
            p_data  = out_data;
            p_last  = out_last;
            m_ovf_pend = 0;
            if (rx_valid === 1'b1) begin
                ok = (m_occ < 2) && (m_pkt.size() < MAXB);
                if (ok) m_pkt.push_back(rx_data);
                else    m_bad = 1;
                if (rx_last === 1'b1) begin
                    if (!m_bad) begin
                        len = m_pkt.size();
                        sum = len;
                        exp_b.push_back(8'hA5);    exp_l.push_back(0);
                        exp_b.push_back(8'(len));  exp_l.push_back(0);
                        foreach (m_pkt[i]) begin
                            sum += m_pkt[i];
                            exp_b.push_back(m_pkt[i]); exp_l.push_back(0);
                        end
                        exp_b.push_back(8'(sum % 256)); exp_l.push_back(1);
                        m_occ++;
                    end else begin
                        if (m_drop < 255) m_drop++;
                        m_ovf_pend = 1;
                    end
                    m_pkt.delete();
                    m_bad = 0;
                end
            end
            if (rel) m_occ--;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        rx_valid = 1'b1;
        rx_data  = d;
        rx_last  = l;
        tick();
        rx_valid = 1'b0;
        rx_last  = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0 ||
            overflow !== 1'b0 || drop_cnt !== 8'h00) begin
            errors++;
            $display("FAIL reset_values v=%b d=%h l=%b ovf=%b drop=%0d want all 0",
                     out_valid, out_data, out_last, overflow, drop_cnt);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] e[$];
        out_ready = 1'b1;
        obs_q.delete(); obs_l.delete();
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_latency1 got valid=%b want 0", out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
            errors++;
            $display("FAIL basic_latency2 got v=%b d=%h want v=1 d=a5", out_valid, out_data);
        end
        repeat (8) tick();
        e = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
        checks++;
        if (obs_q.size() != e.size()) begin
            errors++;
            $display("FAIL basic_count got %0d want %0d", obs_q.size(), e.size());
        end
        foreach (e[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== e[i] || obs_l[i] !== (i == e.size() - 1)) begin
                errors++;
                $display("FAIL basic_byte%0d got %h/%b want %h", i, obs_q[i], obs_l[i], e[i]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] e[$];
        out_ready = 1'b1;
        obs_q.delete(); obs_l.delete();
        for (int i = 0; i < 9; i++) send_byte(8'h55, i == 8);
        checks++;
        if (overflow !== 1'b1 || drop_cnt !== 8'd1) begin
            errors++;
            $display("FAIL ovf_pulse got ovf=%b drop=%0d want 1 1", overflow, drop_cnt);
        end
        tick();
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_single got %b want 0", overflow);
        end
        repeat (4) tick();
        send_byte(8'h01, 1);
        repeat (8) tick();
        e = '{8'hA5, 8'h01, 8'h01, 8'h02};
        checks++;
        if (obs_q.size() != e.size()) begin
            errors++;
            $display("FAIL ovf_count got %0d want %0d", obs_q.size(), e.size());
        end
        foreach (e[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== e[i]) begin
                errors++;
                $display("FAIL ovf_byte%0d got %h want %h", i, obs_q[i], e[i]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] e[$];
        out_ready = 1'b1;
        obs_q.delete(); obs_l.delete();
        for (int i = 0; i < 8; i++) send_byte(8'hFF, i == 7);
        repeat (15) tick();
        e = '{8'hA5, 8'h08, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00};
        checks++;
        if (obs_q.size() != e.size()) begin
            errors++;
            $display("FAIL wrap_count got %0d want %0d", obs_q.size(), e.size());
        end
        foreach (e[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== e[i]) begin
                errors++;
                $display("FAIL wrap_byte%0d got %h want %h", i, obs_q[i], e[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] e[$];
        out_ready = 1'b0;
        obs_q.delete(); obs_l.delete();
        send_byte(8'hAA, 1); repeat (3) tick();
        send_byte(8'hBB, 1); repeat (3) tick();
        send_byte(8'hCC, 1); repeat (3) tick();
        checks++;
        if (drop_cnt !== 8'd2 || obs_q.size() != 0) begin
            errors++;
            $display("FAIL bp_drop got drop=%0d out=%0d want 2 0", drop_cnt, obs_q.size());
        end
        out_ready = 1'b1;
        repeat (12) tick();
        e = '{8'hA5, 8'h01, 8'hAA, 8'hAB, 8'hA5, 8'h01, 8'hBB, 8'hBC};
        checks++;
        if (obs_q.size() != e.size()) begin
            errors++;
            $display("FAIL bp_count got %0d want %0d", obs_q.size(), e.size());
        end
        foreach (e[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== e[i]) begin
                errors++;
                $display("FAIL bp_byte%0d got %h want %h", i, obs_q[i], e[i]);
            end
        end
    endtask

    task automatic test_toggle();
        logic [7:0] e[$];
        out_ready = 1'b0;
        obs_q.delete(); obs_l.delete();
        send_byte(8'h10, 0);
        send_byte(8'h20, 0);
        send_byte(8'h30, 0);
        send_byte(8'h40, 1);
        for (int i = 0; i < 24; i++) begin
            out_ready = ~out_ready;
            tick();
        end
        out_ready = 1'b1;
        e = '{8'hA5, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40, 8'hA4};
        checks++;
        if (obs_q.size() != e.size()) begin
            errors++;
            $display("FAIL toggle_count got %0d want %0d", obs_q.size(), e.size());
        end
        foreach (e[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== e[i]) begin
                errors++;
                $display("FAIL toggle_byte%0d got %h want %h", i, obs_q[i], e[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] e[$];
        out_ready = 1'b1;
        obs_q.delete(); obs_l.delete();
        send_byte(8'hC1, 0);
        send_byte(8'hC2, 1);
        send_byte(8'hD1, 1);
        repeat (14) tick();
        e = '{8'hA5, 8'h02, 8'hC1, 8'hC2, 8'h85, 8'hA5, 8'h01, 8'hD1, 8'hD2};
        checks++;
        if (obs_q.size() != e.size()) begin
            errors++;
            $display("FAIL b2b_count got %0d want %0d", obs_q.size(), e.size());
        end
        foreach (e[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== e[i]) begin
                errors++;
                $display("FAIL b2b_byte%0d got %h want %h", i, obs_q[i], e[i]);
            end
        end
    endtask

    task automatic test_random();
        int len;
        int guard;
        for (int p = 0; p < 200; p++) begin
            len = $urandom_range(1, 9);
            for (int b = 0; b < len; b++) begin
                out_ready = ($urandom_range(0, 3) != 0);
                send_byte(8'($urandom), b == len - 1);
            end
            repeat ($urandom_range(0, 3)) begin
                out_ready = ($urandom_range(0, 3) != 0);
                tick();
            end
        end
        out_ready = 1'b1;
        guard = 0;
        while ((exp_b.size() != 0 || out_valid === 1'b1) && guard < 100) begin
            tick();
            guard++;
        end
        checks++;
        if (exp_b.size() != 0) begin
            errors++;
            $display("FAIL random_drain got %0d pending want 0", exp_b.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] e[$];
        int guard;
        out_ready = 1'b1;
        obs_q.delete(); obs_l.delete();
        for (int i = 0; i < 5; i++) send_byte(8'(i + 1), i == 4);
        guard = 0;
        while (obs_q.size() < 3 && guard < 20) begin
            tick();
            guard++;
        end
        checks++;
        if (obs_q.size() < 3 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL midrst_reach got %0d bytes v=%b want 3 1", obs_q.size(), out_valid);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || drop_cnt !== 8'h00 || out_data !== 8'h00) begin
            errors++;
            $display("FAIL midrst_immediate v=%b drop=%0d d=%h want 0 0 00", out_valid, drop_cnt, out_data);
        end
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        obs_q.delete(); obs_l.delete();
        send_byte(8'h7E, 1);
        repeat (8) tick();
        e = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
        checks++;
        if (obs_q.size() != e.size()) begin
            errors++;
            $display("FAIL midrst_count got %0d want %0d", obs_q.size(), e.size());
        end
        foreach (e[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== e[i]) begin
                errors++;
                $display("FAIL midrst_byte%0d got %h want %h", i, obs_q[i], e[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_wrap();
        test_backpressure();
        test_toggle();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
